// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multiply/divide unit that owns HI/LO.
package muldiv_pkg;

    // Width of the helper's working vector; supports WIDTH up to 127.
    localparam int MD_MAX_W = 256;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    // Conditional two's-complement negation. With neg = sign bit this is abs();
    // with neg = recorded result sign it restores the signed result.
    function automatic logic [MD_MAX_W-1:0] md_neg_if(input logic [MD_MAX_W-1:0] v,
                                                       input logic                neg);
        return neg ? (~v + MD_MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_divider_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// remainder, try subtracting the divisor, and keep the result if it stays
// non-negative. The trial subtract is one bit wider than the operands.
module muldiv_divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial subtract; shifted < 2*divisor so trial[WIDTH] is a true sign bit.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (trial[WIDTH]) begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine owning the HI/LO pair. Operands are
// reduced to magnitudes at start, iterated, and sign-fixed in a final state.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic                signed_op;
    logic [MD_MAX_W-1:0] ext_a, ext_b, ext_acc, ext_quo, ext_rem;
    logic [MD_MAX_W-1:0] abs_a_w, abs_b_w, fix_acc_w, fix_quo_w, fix_rem_w;
    logic [WIDTH-1:0]    abs_a, abs_b;
    logic [WIDTH:0]      mul_sum;
    logic [WIDTH-1:0]    div_rem, div_quo;
    logic                unused_ext;

    // Single divide iteration; the quotient lives in the low half of acc.
    muldiv_divider_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (acc_q[WIDTH-1:0]),
        .divisor_i (opnd_q),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );

    // Operand magnitudes, one shift-add step, and the sign-fixed results.
    always_comb begin
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        ext_a = '0;
        ext_a[WIDTH-1:0] = a;
        ext_b = '0;
        ext_b[WIDTH-1:0] = b;
        abs_a_w = md_neg_if(ext_a, signed_op & a[WIDTH-1]);
        abs_b_w = md_neg_if(ext_b, signed_op & b[WIDTH-1]);
        abs_a = abs_a_w[WIDTH-1:0];
        abs_b = abs_b_w[WIDTH-1:0];
        ext_acc = '0;
        ext_acc[2*WIDTH-1:0] = acc_q;
        ext_quo = '0;
        ext_quo[WIDTH-1:0] = acc_q[WIDTH-1:0];
        ext_rem = '0;
        ext_rem[WIDTH-1:0] = rem_q;
        fix_acc_w = md_neg_if(ext_acc, neg_res_q);
        fix_quo_w = md_neg_if(ext_quo, neg_res_q);
        fix_rem_w = md_neg_if(ext_rem, neg_rem_q);
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opnd_q};
    end

    // Helper bits above the operand width are intentionally discarded.
    assign unused_ext = ^{abs_a_w[MD_MAX_W-1:WIDTH], abs_b_w[MD_MAX_W-1:WIDTH],
                          fix_acc_w[MD_MAX_W-1:2*WIDTH], fix_quo_w[MD_MAX_W-1:WIDTH],
                          fix_rem_w[MD_MAX_W-1:WIDTH]};

    // Control FSM: start decode, iteration, sign fixup and HI/LO writeback.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        MD_MULT, MD_MULTU: begin
                            is_div_d  = 1'b0;
                            neg_res_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem_d = 1'b0;
                            opnd_d    = abs_a;
                            count_d   = '0;
                            if (FAST_MUL) begin
                                acc_d   = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
                                state_d = ST_FIX;
                            end else begin
                                acc_d   = {{WIDTH{1'b0}}, abs_b};
                                state_d = ST_MUL;
                            end
                        end
                        MD_DIV, MD_DIVU: begin
                            is_div_d = 1'b1;
                            count_d  = '0;
                            if (b == '0) begin
                                acc_d     = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                                rem_d     = a;
                                neg_res_d = 1'b0;
                                neg_rem_d = 1'b0;
                                state_d   = ST_FIX;
                            end else begin
                                acc_d     = {{WIDTH{1'b0}}, abs_a};
                                rem_d     = '0;
                                opnd_d    = abs_b;
                                neg_res_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_rem_d = signed_op & a[WIDTH-1];
                                state_d   = ST_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_STEP) state_d = ST_FIX;
                end
            end
            ST_DIV: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = {acc_q[2*WIDTH-1:WIDTH], div_quo};
                    rem_d   = div_rem;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_STEP) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!abort) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = fix_rem_w[WIDTH-1:0];
                        lo_d = fix_quo_w[WIDTH-1:0];
                    end else begin
                        {hi_d, lo_d} = fix_acc_w[2*WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
